spi_initiator: RTL

- SPI controller (initiator) for the on-chip SPI bus.
- Generates sclk and an active-low chip select, shifts data_tx out on mosi, and captures miso into data_rx.
- Supports all four CPOL/CPHA modes. Frames are DATA_W bits, LSB first, full duplex.
- Drives the same wire-level bus as the team's SPI responder blocks. A host issues start/done transactions to it.

---
 rtl/spi_pkg.sv | 24 ++
 rtl/spi_sclk_gen.sv | 72 +++++++
 rtl/spi_initiator.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_pkg
// Brief    : Shared SPI types (FSM states, bus mode) for initiator/responders.
// Revision : 1.0 - initial release
// ============================================================================
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Packs as {cpol, cpha}, matching the 2-bit mode port layout.
    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

endpackage
`default_nettype wire

// File: rtl/spi_sclk_gen.sv
`default_nettype none
// ============================================================================
// Module   : spi_sclk_gen
// Brief    : SPI serial clock generator. Divides clk down to sclk while
//            enabled and flags leading/trailing/final edges of a frame.
// Revision : 1.0 - initial release
// ============================================================================
module spi_sclk_gen #(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic enable_i,
    input  logic cpol_i,
    output logic sclk_o,
    output logic lead_stb_o,
    output logic trail_stb_o,
    output logic last_edge_o
);

    localparam int DIV_W  = $clog2(CLK_DIV);
    localparam int EDGE_W = $clog2(2 * DATA_W) + 1;
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_W - 1);

    logic [DIV_W-1:0]  div_q,  div_d;
    logic [EDGE_W-1:0] edge_q, edge_d;
    logic              sclk_q, sclk_d;
    logic              stb;

    // One strobe per sclk half-period; even edge indices move sclk away
    // from CPOL (leading), odd ones bring it back (trailing).
    assign stb         = enable_i && (div_q == DIV_LAST);
    assign lead_stb_o  = stb && !edge_q[0];
    assign trail_stb_o = stb &&  edge_q[0];
    assign last_edge_o = stb && (edge_q == EDGE_LAST);
    assign sclk_o      = sclk_q;

    // Next-state: counters run only while enabled; idle sclk parks at CPOL.
    always_comb begin
        div_d  = div_q;
        edge_d = edge_q;
        sclk_d = sclk_q;
        if (!enable_i) begin
            div_d  = '0;
            edge_d = '0;
            sclk_d = cpol_i;
        end else if (stb) begin
            div_d  = '0;
            edge_d = edge_q + 1'b1;
            sclk_d = ~sclk_q;
        end else begin
            div_d  = div_q + 1'b1;
        end
    end

    // Divider, edge counter and sclk registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q  <= '0;
            edge_q <= '0;
            sclk_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            edge_q <= edge_d;
            sclk_q <= sclk_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_initiator.sv
`default_nettype none
// ============================================================================
// Module   : spi_initiator
// Brief    : SPI initiator, all four CPOL/CPHA modes, LSB-first full-duplex
//            frames of DATA_W bits with programmable cs setup/hold.
// Revision : 1.0 - initial release
// ============================================================================
module spi_initiator
    import spi_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic [1:0]        mode_i,
    input  logic [DATA_W-1:0] data_tx_i,
    output logic [DATA_W-1:0] data_rx_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              sclk_o,
    output logic              mosi_o,
    input  logic              miso_i,
    output logic              cs_n_o
);

    localparam int PH_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam logic [PH_W-1:0] SETUP_LAST = PH_W'(CS_SETUP - 1);
    localparam logic [PH_W-1:0] HOLD_LAST  = PH_W'(CS_HOLD - 1);

    state_t            state_q;
    spi_mode_t         mode_q;
    logic [DATA_W-1:0] tx_q;
    logic [DATA_W-1:0] rx_q;
    logic [DATA_W-1:0] data_rx_q;
    logic [PH_W-1:0]   ph_q;
    logic              cs_n_q;
    logic              mosi_q;
    logic              busy_q;
    logic              done_q;

    logic gen_en;
    logic gen_cpol;
    logic lead_stb;
    logic trail_stb;
    logic last_edge;
    logic drive_stb;
    logic sample_stb;

    // In IDLE the clock tracks the live mode pin; once a frame is accepted
    // it follows the latched CPOL so pin changes cannot disturb the frame.
    assign gen_en   = (state_q == SHIFT);
    assign gen_cpol = (state_q == IDLE) ? mode_i[1] : mode_q.cpol;

    // CPHA=0 presents bit 0 before the first edge, so later bits go out on
    // trailing edges (none after the final one); CPHA=1 drives on leading.
    assign drive_stb  = mode_q.cpha ? lead_stb  : (trail_stb && !last_edge);
    assign sample_stb = mode_q.cpha ? trail_stb : lead_stb;

    spi_sclk_gen #(
        .DATA_W  (DATA_W),
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk         (clk),
        .reset       (reset),
        .enable_i    (gen_en),
        .cpol_i      (gen_cpol),
        .sclk_o      (sclk_o),
        .lead_stb_o  (lead_stb),
        .trail_stb_o (trail_stb),
        .last_edge_o (last_edge)
    );

    // Frame sequencer with registered cs_n/mosi/busy/done and shift/capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            mode_q    <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            data_rx_q <= '0;
            ph_q      <= '0;
            cs_n_q    <= 1'b1;
            mosi_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        mode_q  <= spi_mode_t'(mode_i);
                        tx_q    <= data_tx_i;
                        rx_q    <= '0;
                        ph_q    <= '0;
                        cs_n_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        if (!mode_i[0]) begin
                            mosi_q <= data_tx_i[0];
                        end
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    if (ph_q == SETUP_LAST) begin
                        ph_q    <= '0;
                        state_q <= SHIFT;
                    end else begin
                        ph_q <= ph_q + 1'b1;
                    end
                end
                SHIFT: begin
                    if (drive_stb) begin
                        // With CPHA=0 bit 0 already left, so the next bit sits at [1].
                        mosi_q <= mode_q.cpha ? tx_q[0] : tx_q[1];
                        tx_q   <= tx_q >> 1;
                    end
                    if (sample_stb) begin
                        rx_q <= {miso_i, rx_q[DATA_W-1:1]};
                    end
                    if (last_edge) begin
                        ph_q    <= '0;
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    if (ph_q == HOLD_LAST) begin
                        ph_q      <= '0;
                        cs_n_q    <= 1'b1;
                        done_q    <= 1'b1;
                        data_rx_q <= rx_q;
                        mosi_q    <= 1'b0;
                        state_q   <= DONE;
                    end else begin
                        ph_q <= ph_q + 1'b1;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign data_rx_o = data_rx_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign mosi_o    = mosi_q;
    assign cs_n_o    = cs_n_q;

endmodule
`default_nettype wire
